// File: rtl/neuron_sequencer.sv
// Presents stored training samples to a neuron, one per request. Optional epoch cap under NEURON_SEQ_EPOCH_LIMIT_EN.
// Latency: request_flag at edge k -> data_ready in cycle k+1. A request held high is served only once.
module neuron_sequencer #(
    parameter int DEPTH      = 64,
    parameter int MAX_EPOCHS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic [6:0]  load_x1,
    input  logic [6:0]  load_x2,
    input  logic [1:0]  load_t,
    input  logic        start,
    input  logic        request_flag,
    input  logic        neuron_done,
    output logic [6:0]  x1_out,
    output logic [6:0]  x2_out,
    output logic [1:0]  t_out,
    output logic        data_ready,
    output logic [31:0] n_out,
    output logic        busy,
    output logic        finished,
    output logic        full,
    output logic        timeout,
    output logic [7:0]  epoch_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_PRESENT,
        S_WAIT_DROP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [7:0]      r_epoch;
    logic [6:0]      r_x1;
    logic [6:0]      r_x2;
    logic [1:0]      r_t;

    logic            w_idle;
    logic            w_full;
    logic            w_load;
    logic [CW-1:0]   w_count_post;
    logic            w_start;
    logic            w_serve;
    logic            w_wrap;
    logic [7:0]      w_epoch_inc;
    logic            w_limit_hit;
    logic [15:0]     w_rd_word;

    assign w_idle       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_full       = (r_count == FULL_CNT);
    assign w_load       = w_idle && load_en && !w_full;
    // Start sees the sample written in the same cycle, so the run includes it.
    assign w_count_post = r_count + CW'(w_load);
    assign w_start      = w_idle && start && (w_count_post != '0);
    assign w_serve      = (r_state == S_WAIT_REQ) && request_flag && !neuron_done;
    assign w_wrap       = ({1'b0, r_rd_ptr} == (r_count - CW'(1)));
    assign w_epoch_inc  = (r_epoch == 8'hFF) ? 8'hFF : (r_epoch + 8'd1);
    assign w_rd_word    = r_mem[r_rd_ptr];

`ifdef NEURON_SEQ_EPOCH_LIMIT_EN
    localparam logic [7:0] EPOCH_LIMIT = 8'(MAX_EPOCHS);
    logic r_timeout;

    assign w_limit_hit = (r_state == S_PRESENT) && w_wrap && (w_epoch_inc == EPOCH_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_timeout <= 1'b0;
        end else if (w_limit_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_limit_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        data_ready = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                finished = (r_state == S_DONE);
                if (w_start) w_next = S_WAIT_REQ;
            end
            S_WAIT_REQ: begin
                busy = 1'b1;
                if (neuron_done)       w_next = S_DONE;
                else if (request_flag) w_next = S_PRESENT;
            end
            S_PRESENT: begin
                busy       = 1'b1;
                data_ready = 1'b1;
                if (neuron_done || w_limit_hit) w_next = S_DONE;
                else                            w_next = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                busy = 1'b1;
                if (neuron_done)        w_next = S_DONE;
                else if (!request_flag) w_next = S_WAIT_REQ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_epoch  <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_t      <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count  <= w_count_post;
            end
            if (w_start) begin
                r_rd_ptr <= '0;
                r_epoch  <= '0;
            end
            if (w_serve) begin
                {r_x1, r_x2, r_t} <= w_rd_word;
            end
            if (r_state == S_PRESENT) begin
                if (w_wrap) begin
                    r_rd_ptr <= '0;
                    r_epoch  <= w_epoch_inc;
                end else begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!rst && w_load) begin
            r_mem[r_wr_ptr] <= {load_x1, load_x2, load_t};
        end
    end

    assign x1_out      = r_x1;
    assign x2_out      = r_x2;
    assign t_out       = r_t;
    assign epoch_count = r_epoch;
    assign full        = w_full;
    assign n_out       = 32'(r_count);

endmodule
